sram_init_bridge: RTL

- Host-to-SRAM bridge with a built-in boot loader, placed between the CPU/bus master and the external SRAM controller.
- After reset it performs two initialisation phases before any host access:
  - writes a fill word FILL_COUNT times to FILL_ADDR;
  - copies INIT_DEPTH words from an external ROM port to SRAM starting at INIT_BASE.
- It then passes host transactions through. A pulse on init_req re-runs the whole sequence at runtime.
- Generalised in widths, depth, base address and fill pattern.

---
 rtl/sram_init_pkg.sv | 23 ++
 rtl/sram_host_mux.sv | 40 ++++
 rtl/sram_init_bridge.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_init_pkg.sv
// Shared state encoding and default boot constants for the SRAM init bridge.
package sram_init_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_FILL = 3'd0;
  localparam state_t S_RD   = 3'd1;
  localparam state_t S_LAT  = 3'd2;
  localparam state_t S_WR   = 3'd3;
  localparam state_t S_VRD  = 3'd4;
  localparam state_t S_VLAT = 3'd5;
  localparam state_t S_VCHK = 3'd6;
  localparam state_t S_DONE = 3'd7;

  localparam logic [19:0] INIT_BASE_DEF = 20'h80000;
  localparam logic [47:0] FILL_DATA_DEF = 48'h000008080000;

  // Keeps counter/address widths at least one bit for degenerate depths.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_host_mux.sv
// Selects between the init engine and the host as the SRAM master.
module sram_host_mux #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 48,
  parameter int HOST_W = 32
) (
  input  logic              init_busy_i,
  input  logic              eng_stb_i,
  input  logic              eng_we_i,
  input  logic [ADDR_W-1:0] eng_addr_i,
  input  logic [DATA_W-1:0] eng_data_i,
  input  logic              host_stb_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [HOST_W-1:0] host_data_i,
  input  logic              sram_ack_i,
  output logic              sram_stb_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_data_o,
  output logic              host_ack_o
);

  always_comb begin
    if (init_busy_i) begin
      sram_stb_o  = eng_stb_i;
      sram_we_o   = eng_we_i;
      sram_addr_o = eng_addr_i;
      sram_data_o = eng_data_i;
    end else begin
      sram_stb_o  = host_stb_i;
      sram_we_o   = host_we_i;
      sram_addr_o = host_addr_i;
      sram_data_o = host_we_i ? DATA_W'(host_data_i) : '0;
    end
    // The host is stalled, never acknowledged, while the engine owns the SRAM.
    host_ack_o = !init_busy_i && host_stb_i && sram_ack_i;
  end

endmodule

// File: rtl/sram_init_bridge.sv
// Host-to-SRAM bridge with fill + ROM-copy boot loader; define SRAM_INIT_VERIFY_EN
// to add a readback pass that raises a sticky init_err on any mismatch.
module sram_init_bridge
  import sram_init_pkg::*;
#(
  parameter int                ADDR_W     = 20,
  parameter int                DATA_W     = 48,
  parameter int                HOST_W     = 32,
  parameter int                INIT_DEPTH = 128,
  parameter logic [ADDR_W-1:0] INIT_BASE  = ADDR_W'(INIT_BASE_DEF),
  parameter logic [ADDR_W-1:0] FILL_ADDR  = '0,
  parameter logic [DATA_W-1:0] FILL_DATA  = DATA_W'(FILL_DATA_DEF),
  parameter int                FILL_COUNT = 3
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    stb,
  input  logic [ADDR_W-1:0]                       addra,
  input  logic [HOST_W-1:0]                       dina,
  input  logic                                    wea,
  output logic [DATA_W-1:0]                       douta,
  output logic                                    ack,
  input  logic                                    init_req,
  output logic                                    init_busy,
  output logic                                    init_done,
`ifdef SRAM_INIT_VERIFY_EN
  output logic                                    init_err,
`endif
  output logic [safe_clog2(INIT_DEPTH)-1:0]       rom_addr,
  input  logic [DATA_W-1:0]                       rom_data,
  output logic                                    sram_stb,
  output logic [ADDR_W-1:0]                       sram_addra,
  output logic [DATA_W-1:0]                       sram_dina,
  output logic                                    sram_we,
  input  logic [DATA_W-1:0]                       sram_douta,
  input  logic                                    sram_ack
);

  localparam int ROM_AW = safe_clog2(INIT_DEPTH);
  localparam int FC_W   = safe_clog2(FILL_COUNT + 1);
  localparam logic [ROM_AW-1:0] LAST_IDX  = ROM_AW'(INIT_DEPTH - 1);
  localparam logic [FC_W-1:0]   LAST_FILL = FC_W'((FILL_COUNT > 0) ? FILL_COUNT - 1 : 0);
  localparam state_t            START_ST  = (FILL_COUNT > 0) ? S_FILL : S_RD;

  state_t              state_q, state_d;
  logic [ROM_AW-1:0]   idx_q, idx_d;
  logic [FC_W-1:0]     fill_cnt_q, fill_cnt_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                eng_stb_q, eng_stb_d;
  logic                eng_we_q, eng_we_d;
  logic [ADDR_W-1:0]   eng_addr_q, eng_addr_d;
  logic [DATA_W-1:0]   eng_data_q, eng_data_d;
`ifdef SRAM_INIT_VERIFY_EN
  logic                err_q, err_d;
`endif

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    fill_cnt_d = fill_cnt_q;
    wr_data_d  = wr_data_q;
`ifdef SRAM_INIT_VERIFY_EN
    err_d      = err_q;
`endif
    case (state_q)
      S_FILL: if (sram_ack) begin
        if (fill_cnt_q == LAST_FILL) state_d = S_RD;
        else                         fill_cnt_d = fill_cnt_q + 1'b1;
      end
      S_RD:  state_d = S_LAT;
      S_LAT: begin
        wr_data_d = rom_data;
        state_d   = S_WR;
      end
      S_WR: if (sram_ack) begin
        if (idx_q == LAST_IDX) begin
`ifdef SRAM_INIT_VERIFY_EN
          state_d = S_VRD;
          idx_d   = '0;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_RD;
        end
      end
`ifdef SRAM_INIT_VERIFY_EN
      S_VRD:  state_d = S_VLAT;
      S_VLAT: begin
        wr_data_d = rom_data;
        state_d   = S_VCHK;
      end
      S_VCHK: if (sram_ack) begin
        if (sram_douta != wr_data_q) err_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_VRD;
        end
      end
`endif
      S_DONE: if (init_req && !stb) begin
        state_d    = START_ST;
        idx_d      = '0;
        fill_cnt_d = '0;
`ifdef SRAM_INIT_VERIFY_EN
        err_d      = 1'b0;
`endif
      end
      default: state_d = START_ST;
    endcase

    busy_d = (state_d != S_DONE);
    done_d = (state_d == S_DONE);

    // Engine outputs are registered from the next state so they hold steady while stb is high.
    eng_stb_d  = 1'b0;
    eng_we_d   = 1'b0;
    eng_addr_d = '0;
    eng_data_d = '0;
    case (state_d)
      S_FILL: begin
        eng_stb_d  = 1'b1;
        eng_we_d   = 1'b1;
        eng_addr_d = FILL_ADDR;
        eng_data_d = FILL_DATA;
      end
      S_WR: begin
        eng_stb_d  = 1'b1;
        eng_we_d   = 1'b1;
        eng_addr_d = INIT_BASE + ADDR_W'(idx_d);
        eng_data_d = wr_data_d;
      end
`ifdef SRAM_INIT_VERIFY_EN
      S_VCHK: begin
        eng_stb_d  = 1'b1;
        eng_addr_d = INIT_BASE + ADDR_W'(idx_d);
      end
`endif
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= START_ST;
      idx_q      <= '0;
      fill_cnt_q <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      eng_stb_q  <= 1'b0;
      eng_we_q   <= 1'b0;
      eng_addr_q <= '0;
      eng_data_q <= '0;
`ifdef SRAM_INIT_VERIFY_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fill_cnt_q <= fill_cnt_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      eng_stb_q  <= eng_stb_d;
      eng_we_q   <= eng_we_d;
      eng_addr_q <= eng_addr_d;
      eng_data_q <= eng_data_d;
`ifdef SRAM_INIT_VERIFY_EN
      err_q      <= err_d;
`endif
    end
  end

  assign init_busy = busy_q;
  assign init_done = done_q;
  assign rom_addr  = idx_q;
  assign douta     = DATA_W'(sram_douta[HOST_W-1:0]);
`ifdef SRAM_INIT_VERIFY_EN
  assign init_err  = err_q;
`endif

  logic unused_douta_hi;
  assign unused_douta_hi = ^(sram_douta >> HOST_W);

  sram_host_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .HOST_W(HOST_W)
  ) u_mux (
    .init_busy_i(busy_q),
    .eng_stb_i  (eng_stb_q),
    .eng_we_i   (eng_we_q),
    .eng_addr_i (eng_addr_q),
    .eng_data_i (eng_data_q),
    .host_stb_i (stb),
    .host_we_i  (wea),
    .host_addr_i(addra),
    .host_data_i(dina),
    .sram_ack_i (sram_ack),
    .sram_stb_o (sram_stb),
    .sram_we_o  (sram_we),
    .sram_addr_o(sram_addra),
    .sram_data_o(sram_dina),
    .host_ack_o (ack)
  );

endmodule
